inv_mixcolumn_seq: RTL and testbench
====================================

# inv_mixcolumn_seq

Iterative AES InvMixColumns unit with fused AddRoundKey for the decryption datapath. Accepts one 128-bit state plus round key over a valid/ready handshake, XORs them, then applies InvMixColumns over COLS_PER_CYCLE columns per clock. The result is presented on a valid/ready output port. It sits after InvSubBytes/InvShiftRows in the inverse-cipher round loop. A per-block bypass covers the final round, which performs AddRoundKey only.

## Interface
- COLS_PER_CYCLE, 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input block offered.
- in_ready  out  1  block accepted when in_valid && in_ready at a rising edge.
- in_data  in  128  state; column c = in_data[127-32c -: 32]; byte 0 of a column = bits [31:24].
- in_key  in  128  round key, same layout, sampled with in_data.
- in_bypass  in  1  1 = AddRoundKey only; skip InvMixColumns.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  128  result, same layout.
- busy  out  1  high in CALC or DONE.

## Operation
- Column math, over GF(2^8) with poly 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from xtime chains: x2, x4, x8; 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On accept: work register <= in_data ^ in_key; col counter <= 0; bypass latched.
  - Next state is DONE if in_bypass, else CALC.
- CALC:
  - Each cycle, columns [col, col+COLS_PER_CYCLE-1] of the work register are replaced in place by their InvMixColumns result.
  - col advances by COLS_PER_CYCLE, wrapping modulo 4.
  - After the cycle that processes column 3, next state is DONE.
  - in_ready = 0.
- DONE:
  - out_valid = 1; out_data = work register, held stable until handshake.
  - On out_ready the state returns to IDLE.
  - in_ready = 0 in DONE, so there is no same-cycle re-accept.
- in_key and in_bypass are don't-care except at the accept edge.
- The work register is the out_data register; there is no separate output copy.

## Timing
- Reset (any state, including mid-CALC or DONE):
  - State -> IDLE, col = 0, out_valid = 0, out_data = 0, busy = 0.
  - in_ready is forced to 0 while rst = 1 and is 1 in the first cycle after release.
  - An in-flight block is discarded and never emitted.
- Latency, counted from the accept edge T to the first cycle with out_valid = 1:
  - 4/COLS_PER_CYCLE + 1 cycles (5, 3 and 2 for C = 1, 2, 4).
  - Bypass: 1 cycle, so out_valid is high in cycle T+1.
- Throughput with out_ready held high: one block per latency + 1 cycles. Accept in IDLE, emit in DONE, return to IDLE.
- Backpressure: out_valid stays asserted and out_data does not change until out_ready. in_ready stays 0 throughout.
- out_valid does not depend combinationally on out_ready. in_ready depends only on state and rst.

## Structure
- Shared package aes_pkg holds:
  - state enum inv_mc_state_t {IDLE, CALC, DONE};
  - functions xtime(byte) and gmul9/gmulb/gmuld/gmule;
  - function inv_mix_col(32-bit) -> 32-bit;
  - column/byte index constants.
- One combinational sub-module, inv_mul_32 (32-bit column in, 32-bit column out), wraps inv_mix_col. It is instantiated COLS_PER_CYCLE times via generate, indexed off col.

## Test plan
- Known columns, C=1: in_data = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}, in_key = 0, in_bypass = 0 -> out_data = {db135345, f20a225c, 01010101, c6c6c6c6}, out_valid first high at T+5.
- Key fusion: in_data = 0, in_key = {4d7ebdf8, d5d5d7d6, 8e4da1bc, 9fdc589d} -> out_data = {2d26314c, d4d4d4d5, db135345, f20a225c}.
- Bypass: in_data = 00112233_44556677_8899aabb_ccddeeff, in_key = 000102…0f, in_bypass = 1 -> out_data = 00102030_40506070_8090a0b0_c0d0e0f0 at T+1.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_data constant, out_valid high, in_ready 0. Raise out_ready -> handshake, then in_ready = 1 in the next cycle.
- Reset mid-CALC (after 2 columns): rst for 1 cycle -> out_valid = 0, out_data = 0, in_ready = 1 after release. No stale output appears; the next block produces a correct result.
- Sweep C = 1, 2, 4: latencies 5/3/2. 1000 random blocks pass through the forward MixColumns model then this block with key = 0 -> original data recovered. Random out_ready stalls are applied.

Source files
------------

// File: rtl/inv_mixcolumn_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg: GF(2^8) helpers and shared types for the InvMixColumns unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } inv_mc_state_t;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmulb(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmuld(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmule(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte 0 of a column sits in the most significant byte.
  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] a);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    a0 = a[4*BYTE_W-1 -: BYTE_W];
    a1 = a[3*BYTE_W-1 -: BYTE_W];
    a2 = a[2*BYTE_W-1 -: BYTE_W];
    a3 = a[1*BYTE_W-1 -: BYTE_W];
    return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
            gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
            gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
            gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

  function automatic int col_lsb(input logic [1:0] c);
    return (NUM_COLS - 1 - int'(c)) * COL_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mixcolumn_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_mixcolumn_seq_if: block in/out handshake bundle                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface inv_mixcolumn_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, in_key, in_bypass, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_key, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/inv_mixcolumn_seq_inv_mul_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_mul_32: combinational InvMixColumns on one 32-bit column         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_mul_32
  import aes_pkg::*;
(
  input  wire logic [31:0] i_col,
  output logic      [31:0] o_col
);
  assign o_col = inv_mix_col(i_col);
endmodule
`default_nettype wire

// File: rtl/inv_mixcolumn_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_mixcolumn_seq: iterative AddRoundKey + InvMixColumns             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_mixcolumn_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input wire logic           clk,
  input wire logic           rst,
  inv_mixcolumn_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [1:0] C_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] C_LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [1:0]       r_state;
  logic [1:0]       r_col;
  logic [127:0]     r_work;
  logic [1:0]       w_idx  [COLS_PER_CYCLE];
  logic [COL_W-1:0] w_cin  [COLS_PER_CYCLE];
  logic [COL_W-1:0] w_cout [COLS_PER_CYCLE];

  // r_col is always a multiple of COLS_PER_CYCLE, so the group never wraps.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_idx[g] = r_col + 2'(g);
    assign w_cin[g] = r_work[col_lsb(w_idx[g]) +: COL_W];
    inv_mul_32 u_mul (
      .i_col (w_cin[g]),
      .o_col (w_cout[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
      r_work  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in_data ^ bus.in_key;
            r_col   <= 2'd0;
            r_state <= bus.in_bypass ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            r_work[col_lsb(w_idx[g]) +: COL_W] <= w_cout[g];
          end
          r_col <= r_col + C_STEP;
          if (r_col == C_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_work;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcolumn_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inv_mixcolumn_seq: directed and round-trip bench, C = 1, 2, 4     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_inv_mixcolumn_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  inv_mixcolumn_seq_if if1 ();
  inv_mixcolumn_seq_if if2 ();
  inv_mixcolumn_seq_if if4 ();

  inv_mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  inv_mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  inv_mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  virtual inv_mixcolumn_seq_if v1, v2, v4;

  localparam logic [127:0] KNOWN_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KNOWN_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FUSE_KEY  = 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d;
  localparam logic [127:0] FUSE_OUT  = 128'h2d26314c_d4d4d4d5_db135345_f20a225c;
  localparam logic [127:0] BYP_IN    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BYP_KEY   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] BYP_OUT   = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3,
                           m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a rising edge; returns just after the output handshake edge.
  task automatic xfer(input virtual inv_mixcolumn_seq_if vif, input logic [127:0] d,
                      input logic [127:0] k, input logic byp, input int stall,
                      output logic [127:0] res, output int lat);
    int n = 0;
    vif.in_data   = d;
    vif.in_key    = k;
    vif.in_bypass = byp;
    vif.in_valid  = 1'b1;
    while (!vif.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    vif.in_valid  = 1'b0;
    vif.in_data   = rnd128();
    vif.in_key    = rnd128();
    vif.in_bypass = ~byp;
    lat = 1;
    while (!vif.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = vif.out_data;
    if (!vif.out_valid) begin
      check("out_valid_timeout", 1'b0, 1'b1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", vif.out_valid, 1'b1);
      check("hold_data", vif.out_data, res);
      check("hold_in_ready", vif.in_ready, 1'b0);
    end
    vif.out_ready = 1'b1;
    @(posedge clk); #1;
    vif.out_ready = 1'b0;
  endtask

  task automatic roundtrip(input virtual inv_mixcolumn_seq_if vif, input string tag, input int blocks);
    logic [127:0] d, res;
    int lat;
    for (int i = 0; i < blocks; i++) begin
      d = rnd128();
      xfer(vif, fwd_mix(d), '0, 1'b0, int'($urandom_range(0, 3)), res, lat);
      check(tag, res, d);
    end
  endtask

  task automatic init_if(input virtual inv_mixcolumn_seq_if vif);
    vif.in_valid  = 1'b0;
    vif.in_data   = '0;
    vif.in_key    = '0;
    vif.in_bypass = 1'b0;
    vif.out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] res;
    int lat;
    v1 = if1;
    v2 = if2;
    v4 = if4;
    init_if(v1);
    init_if(v2);
    init_if(v4);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", if1.in_ready, 1'b0);
    check("rst_out_valid", if1.out_valid, 1'b0);
    check("rst_out_data", if1.out_data, '0);
    check("rst_busy", if1.busy, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", if1.in_ready, 1'b1);

    xfer(v1, KNOWN_IN, '0, 1'b0, 0, res, lat);
    check("known_data", res, KNOWN_OUT);
    check("known_lat_c1", lat, 5);

    xfer(v1, '0, FUSE_KEY, 1'b0, 0, res, lat);
    check("fuse_data", res, FUSE_OUT);

    xfer(v1, BYP_IN, BYP_KEY, 1'b1, 0, res, lat);
    check("bypass_data", res, BYP_OUT);
    check("bypass_lat", lat, 1);

    xfer(v1, KNOWN_IN, '0, 1'b0, 10, res, lat);
    check("bp_data", res, KNOWN_OUT);
    check("bp_in_ready_after", if1.in_ready, 1'b1);

    // Abort a block after two columns and make sure nothing leaks out.
    if1.in_data  = KNOWN_IN;
    if1.in_key   = '0;
    if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", if1.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_in_rst", if1.in_ready, 1'b0);
    check("midrst_out_valid", if1.out_valid, 1'b0);
    check("midrst_out_data", if1.out_data, '0);
    check("midrst_busy", if1.busy, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", if1.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", if1.out_valid, 1'b0);
    xfer(v1, KNOWN_IN, '0, 1'b0, 0, res, lat);
    check("midrst_next_data", res, KNOWN_OUT);

    xfer(v2, KNOWN_IN, '0, 1'b0, 0, res, lat);
    check("known_data_c2", res, KNOWN_OUT);
    check("known_lat_c2", lat, 3);
    xfer(v4, KNOWN_IN, '0, 1'b0, 0, res, lat);
    check("known_data_c4", res, KNOWN_OUT);
    check("known_lat_c4", lat, 2);
    xfer(v4, BYP_IN, BYP_KEY, 1'b1, 0, res, lat);
    check("bypass_data_c4", res, BYP_OUT);
    check("bypass_lat_c4", lat, 1);

    roundtrip(v1, "rt_c1", 1000);
    roundtrip(v2, "rt_c2", 1000);
    roundtrip(v4, "rt_c4", 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
